// File: rtl/cdc_pkg.sv
// Shared types and defaults for the 4-phase handshake receiver.
package cdc_pkg;

  localparam int unsigned DW_DEF  = 8;
  localparam int unsigned CW_DEF  = 8;
  localparam int unsigned TMO_DEF = 255;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_RDY    = 2'd1,
    WAIT_REQ_LO = 2'd2
  } state_e;

  function automatic int unsigned tmo_width(input int unsigned tmo);
    return $clog2(tmo + 1);
  endfunction

endpackage

// File: rtl/cdc_hs_rx_if.sv
// Handshake bundle between the clka-side sender and the clkb-side receiver/consumer.
interface cdc_hs_rx_if #(
  parameter int unsigned DW = 8
) ();

  logic          req_sync;
  logic [DW-1:0] data_a;
  logic          ack_b;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;

  modport master (
    output req_sync, data_a, dout_ready,
    input  ack_b, dout, dout_valid
  );

  modport slave (
    input  req_sync, data_a, dout_ready,
    output ack_b, dout, dout_valid
  );

endinterface

// File: rtl/cdc_tmo_cnt.sv
// Clearable up-counter that flags expiry once it reaches TMO-1.
module cdc_tmo_cnt
  import cdc_pkg::*;
#(
  parameter int unsigned TMO = TMO_DEF
) (
  input  logic clkb,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned W = tmo_width(TMO);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clkb or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == W'(TMO - 1));

endmodule

// File: rtl/cdc_hs_rx.sv
// Receive side of a 4-phase req/ack crossing: captures data_a on req rise,
// offers it on valid/ready, and returns ack once the word is consumed.
module cdc_hs_rx
  import cdc_pkg::*;
#(
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned CW  = CW_DEF,
  parameter int unsigned TMO = TMO_DEF
) (
  input  logic          clkb,
  input  logic          rst,
  cdc_hs_rx_if.slave    io_hs,
  output logic [CW-1:0] o_xfer_cnt,
  output logic          o_proto_err,
  output logic          o_timeout_err
);

  state_e        r_state;
  logic          r_req_d;
  logic          r_ack;
  logic          r_valid;
  logic [DW-1:0] r_dout;
  logic [CW-1:0] r_cnt;
  logic          r_perr;
  logic          r_terr;

  logic w_rise;
  logic w_fall;
  logic w_accept;
  logic w_tmo_load;
  logic w_tmo_en;
  logic w_tmo_exp;

  assign w_rise     = io_hs.req_sync & ~r_req_d;
  assign w_fall     = ~io_hs.req_sync & r_req_d;
  assign w_accept   = r_valid & io_hs.dout_ready;
  assign w_tmo_load = (r_state == WAIT_RDY) & w_accept;
  assign w_tmo_en   = (r_state == WAIT_REQ_LO) & io_hs.req_sync;

  cdc_tmo_cnt #(
    .TMO (TMO)
  ) u_tmo_cnt (
    .clkb     (clkb),
    .rst      (rst),
    .i_load   (w_tmo_load),
    .i_en     (w_tmo_en),
    .o_expire (w_tmo_exp)
  );

  always_ff @(posedge clkb or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_req_d <= 1'b0;
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      r_dout  <= '0;
      r_cnt   <= '0;
      r_perr  <= 1'b0;
      r_terr  <= 1'b0;
    end else begin
      r_req_d <= io_hs.req_sync;
      case (r_state)
        IDLE: begin
          if (w_rise) begin
            r_dout  <= io_hs.data_a;
            r_valid <= 1'b1;
            r_state <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            r_cnt   <= r_cnt + 1'b1;
            // Word is delivered, but the sender already withdrew req: no ack.
            if (w_fall) begin
              r_perr  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_ack   <= 1'b1;
              r_state <= WAIT_REQ_LO;
            end
          end else if (w_fall) begin
            r_valid <= 1'b0;
            r_perr  <= 1'b1;
            r_state <= IDLE;
          end
        end
        WAIT_REQ_LO: begin
          if (!io_hs.req_sync) begin
            r_ack   <= 1'b0;
            r_state <= IDLE;
          end else if (w_tmo_exp) begin
            r_terr  <= 1'b1;
            r_ack   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_hs.ack_b      = r_ack;
  assign io_hs.dout       = r_dout;
  assign io_hs.dout_valid = r_valid;
  assign o_xfer_cnt       = r_cnt;
  assign o_proto_err      = r_perr;
  assign o_timeout_err    = r_terr;

endmodule
